// File: rtl/eth_phy_reset_seq_if.sv
// Board-side signal bundle for the Ethernet PHY reset sequencer.
// The master drives reset requests and link status; the slave (sequencer) drives the resets.
`timescale 1ns/1ps
interface eth_phy_reset_seq_if #(
  parameter int NUM_SRC = 2,
  parameter int NUM_PHY = 1
);
  logic [NUM_SRC-1:0] rst_src_i;
  logic [NUM_PHY-1:0] phy_rst_req_i;
  logic [NUM_PHY-1:0] link_i;
  logic               soc_reset_o;
  logic [NUM_PHY-1:0] phy_reset_n_o;
  logic [NUM_PHY-1:0] phy_busy_o;
  logic               seq_active_o;

  modport master (
    output rst_src_i, phy_rst_req_i, link_i,
    input  soc_reset_o, phy_reset_n_o, phy_busy_o, seq_active_o
  );

  modport slave (
    input  rst_src_i, phy_rst_req_i, link_i,
    output soc_reset_o, phy_reset_n_o, phy_busy_o, seq_active_o
  );
endinterface

// File: rtl/eth_phy_reset_seq.sv
// Reset/PHY power-up sequencer: PHY_RST -> PHY_WAIT -> RUN with per-PHY soft resets in RUN.
// Optional macro ETH_PHY_RST_LINK_WAIT_EN makes PHY_WAIT also wait for all links (with timeout).
`timescale 1ns/1ps
module eth_phy_reset_seq #(
  parameter int NUM_SRC      = 2,
  parameter int NUM_PHY      = 1,
  parameter int PHY_RST_CYC  = 500000,
  parameter int PHY_WAIT_CYC = 250000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  eth_phy_reset_seq_if.slave    bus
);

  localparam int MAX_CYC = (PHY_RST_CYC > 2*PHY_WAIT_CYC) ? PHY_RST_CYC : 2*PHY_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PHY_RST_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(PHY_RST_CYC);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PHY_WAIT_CYC - 1);
`ifdef ETH_PHY_RST_LINK_WAIT_EN
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(2*PHY_WAIT_CYC - 1);
`endif

  typedef enum logic [1:0] {
    PHY_RST  = 2'd0,
    PHY_WAIT = 2'd1,
    RUN      = 2'd2
  } state_t;

  // Reset synchroniser: asynchronous assertion, release two edges after reset_n rises
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [NUM_SRC-1:0] r_src_meta;
  logic [NUM_SRC-1:0] r_src_sync;
  logic               w_src_any;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_src_meta <= '0;
      r_src_sync <= '0;
    end else begin
      r_src_meta <= bus.rst_src_i;
      r_src_sync <= r_src_meta;
    end
  end

  assign w_src_any = |r_src_sync;

  logic w_wait_done;

`ifdef ETH_PHY_RST_LINK_WAIT_EN
  logic [NUM_PHY-1:0] r_link_meta;
  logic [NUM_PHY-1:0] r_link_sync;
  logic               w_link_all;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_link_meta <= '0;
      r_link_sync <= '0;
    end else begin
      r_link_meta <= bus.link_i;
      r_link_sync <= r_link_meta;
    end
  end

  assign w_link_all = &r_link_sync;
`else
  // Link status has no effect in this build; the reduction only keeps the input referenced
  logic w_unused_link;
  assign w_unused_link = ^bus.link_i;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

`ifdef ETH_PHY_RST_LINK_WAIT_EN
  assign w_wait_done = (r_cnt >= WAIT_LAST) && (w_link_all || (r_cnt >= TMO_LAST));
`else
  assign w_wait_done = (r_cnt >= WAIT_LAST);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_src_any) begin
      w_state_nxt = PHY_RST;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        PHY_RST: begin
          if (r_cnt >= RST_LAST) begin
            w_state_nxt = PHY_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        PHY_WAIT: begin
          if (w_wait_done) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        RUN: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = PHY_RST;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Requests are latched only while already in RUN, so the next edge can load the channel
  logic [NUM_PHY-1:0] r_req;
  logic [NUM_PHY-1:0] w_req_nxt;
  logic [CNT_W-1:0]   r_ch_cnt     [NUM_PHY];
  logic [CNT_W-1:0]   w_ch_cnt_nxt [NUM_PHY];
  logic [NUM_PHY-1:0] w_busy_nxt;

  assign w_req_nxt = ((r_state == RUN) && !w_src_any) ? bus.phy_rst_req_i : '0;

  always_comb begin
    w_busy_nxt = '0;
    for (int i = 0; i < NUM_PHY; i++) begin
      w_ch_cnt_nxt[i] = '0;
      if (w_state_nxt == RUN) begin
        if (r_req[i])
          w_ch_cnt_nxt[i] = RST_LOAD;
        else if (r_ch_cnt[i] != '0)
          w_ch_cnt_nxt[i] = r_ch_cnt[i] - 1'b1;
      end
      if (w_state_nxt == PHY_RST)
        w_busy_nxt[i] = 1'b1;
      else if (w_state_nxt == RUN)
        w_busy_nxt[i] = (w_ch_cnt_nxt[i] != '0);
    end
  end

  logic               r_soc_reset;
  logic [NUM_PHY-1:0] r_phy_reset_n;
  logic [NUM_PHY-1:0] r_phy_busy;
  logic               r_seq_active;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= PHY_RST;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
    end
  end

  // Outputs are registered from next-state values so they change on the same edge as the FSM
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NUM_PHY; i++) r_ch_cnt[i] <= '0;
      r_soc_reset   <= 1'b1;
      r_phy_reset_n <= '0;
      r_phy_busy    <= '1;
      r_seq_active  <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_PHY; i++) r_ch_cnt[i] <= w_ch_cnt_nxt[i];
      r_soc_reset   <= (w_state_nxt != RUN);
      r_phy_reset_n <= ~w_busy_nxt;
      r_phy_busy    <= w_busy_nxt;
      r_seq_active  <= (w_state_nxt != RUN);
    end
  end

  assign bus.soc_reset_o   = r_soc_reset;
  assign bus.phy_reset_n_o = r_phy_reset_n;
  assign bus.phy_busy_o    = r_phy_busy;
  assign bus.seq_active_o  = r_seq_active;

endmodule

// File: tb/tb_eth_phy_reset_seq.sv
// Bench for eth_phy_reset_seq: timestamp-based model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_eth_phy_reset_seq;
  localparam int NSRC = 2;
  localparam int NPHY = 2;
  localparam int RST  = 8;
  localparam int WT   = 4;
  localparam int INF  = 1 << 30;

  logic clk;
  logic reset_n;

  eth_phy_reset_seq_if #(.NUM_SRC(NSRC), .NUM_PHY(NPHY)) bus();

  eth_phy_reset_seq #(
    .NUM_SRC(NSRC), .NUM_PHY(NPHY), .PHY_RST_CYC(RST), .PHY_WAIT_CYC(WT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n = 0;
  bit started = 0;
  bit checking = 0;

  // Model: S = last edge that saw a synchronised source (sequence restart), run_at = edge RUN began
  int S = 2;
  int run_at = INF;
  int ch_end [NPHY] = '{-1, -1};
  bit pend   [NPHY] = '{1'b0, 1'b0};
  bit src_raw  [4096];
  bit link_raw [4096];

  initial begin
    bit s_any;
    bit l_ok;
    bit [NPHY-1:0] req;
    int w;
    forever begin
      @(posedge clk);
      if (started) begin
        n = n + 1;
        src_raw[n]  = |bus.rst_src_i;
        link_raw[n] = &bus.link_i;
        req         = bus.phy_rst_req_i;
        s_any = (n >= 5) ? src_raw[n-2] : 1'b0;
        l_ok  = (n >= 5) ? link_raw[n-2] : 1'b0;
        if (s_any) begin
          S = n;
          run_at = INF;
          for (int i = 0; i < NPHY; i++) begin ch_end[i] = -1; pend[i] = 1'b0; end
        end else begin
          if (run_at == INF) begin
            w = n - S - RST;
`ifdef ETH_PHY_RST_LINK_WAIT_EN
            if (w >= WT && (l_ok || w >= 2*WT)) run_at = n;
`else
            if (w >= WT) run_at = n;
`endif
          end
          for (int i = 0; i < NPHY; i++) begin
            if (pend[i]) ch_end[i] = n + RST - 1;
            pend[i] = (run_at <= n - 1) && req[i];
          end
        end
      end
    end
  end

  function automatic logic [5:0] model_out();
    logic [NPHY-1:0] b;
    b = '0;
    if (run_at <= n) begin
      for (int i = 0; i < NPHY; i++) b[i] = (n <= ch_end[i]);
      return {1'b0, 1'b0, b, ~b};
    end else if (n - S < RST) begin
      return {1'b1, 1'b1, 2'b11, 2'b00};
    end
    return {1'b1, 1'b1, 2'b00, 2'b11};
  endfunction

  initial begin
    logic [5:0] got;
    logic [5:0] expv;
    forever begin
      @(negedge clk);
      if (checking) begin
        expv = model_out();
        got  = {bus.soc_reset_o, bus.seq_active_o, bus.phy_busy_o, bus.phy_reset_n_o};
        tests++;
        if (got !== expv) begin
          fails++;
          $display("FAIL model edge=%0d got={soc,act,busy,rstn}=%b expected=%b", n, got, expv);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, n, act, expv);
    end
  endtask

  task automatic at_edge(input int e);
    int guard;
    guard = 0;
    while (n < e && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (n != e) begin
      tests++;
      fails++;
      $display("FAIL at_edge reached=%0d expected=%0d", n, e);
    end
  endtask

  initial begin
    #40000;
    $display("FAIL watchdog edge=%0d", n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    bus.rst_src_i     = '0;
    bus.phy_rst_req_i = '0;
    bus.link_i        = 2'b11;
    repeat (3) @(negedge clk);
    reset_n  = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_soc",  8'(bus.soc_reset_o),   8'h1);
    check("rst_rstn", 8'(bus.phy_reset_n_o), 8'h0);
    check("rst_busy", 8'(bus.phy_busy_o),    8'h3);
    check("rst_act",  8'(bus.seq_active_o),  8'h1);

    reset_n = 1'b1;
    started = 1'b1;
    at_edge(9);  check("pwr_rstn_9",  8'(bus.phy_reset_n_o), 8'h0);
    at_edge(10); check("pwr_rstn_10", 8'(bus.phy_reset_n_o), 8'h3);
                 check("pwr_busy_10", 8'(bus.phy_busy_o),    8'h0);
    at_edge(13); check("pwr_soc_13",  8'(bus.soc_reset_o),   8'h1);
    at_edge(14); check("pwr_soc_14",  8'(bus.soc_reset_o),   8'h0);
                 check("pwr_act_14",  8'(bus.seq_active_o),  8'h0);

    at_edge(20); bus.phy_rst_req_i = 2'b01;
    at_edge(21); bus.phy_rst_req_i = 2'b00;
                 check("phy0_rstn_21", 8'(bus.phy_reset_n_o), 8'h3);
    at_edge(22); check("phy0_rstn_22", 8'(bus.phy_reset_n_o), 8'h2);
                 check("phy0_busy_22", 8'(bus.phy_busy_o),    8'h1);
                 check("phy0_soc_22",  8'(bus.soc_reset_o),   8'h0);
    at_edge(29); check("phy0_rstn_29", 8'(bus.phy_reset_n_o), 8'h2);
    at_edge(30); check("phy0_rstn_30", 8'(bus.phy_reset_n_o), 8'h3);

    at_edge(39); bus.phy_rst_req_i = 2'b01;
    at_edge(40); bus.phy_rst_req_i = 2'b00;
    at_edge(44); bus.phy_rst_req_i = 2'b01;
    at_edge(45); bus.phy_rst_req_i = 2'b00;
    at_edge(49); check("rereq_rstn_49", 8'(bus.phy_reset_n_o), 8'h2);
    at_edge(53); check("rereq_rstn_53", 8'(bus.phy_reset_n_o), 8'h2);
    at_edge(54); check("rereq_rstn_54", 8'(bus.phy_reset_n_o), 8'h3);

    at_edge(60); bus.rst_src_i = 2'b10;
    at_edge(62); check("src_soc_62",  8'(bus.soc_reset_o),   8'h0);
    at_edge(63); check("src_soc_63",  8'(bus.soc_reset_o),   8'h1);
                 check("src_rstn_63", 8'(bus.phy_reset_n_o), 8'h0);
    at_edge(80); bus.rst_src_i = 2'b00;
    at_edge(89); check("src_rstn_89", 8'(bus.phy_reset_n_o), 8'h0);
    at_edge(90); check("src_rstn_90", 8'(bus.phy_reset_n_o), 8'h3);
    at_edge(94); check("src_soc_94",  8'(bus.soc_reset_o),   8'h0);

    at_edge(99);  bus.phy_rst_req_i = 2'b01;
    at_edge(100); bus.phy_rst_req_i = 2'b00;
    at_edge(102); bus.rst_src_i = 2'b01;
    at_edge(103); bus.rst_src_i = 2'b00;
    at_edge(104); check("abort_rstn_104", 8'(bus.phy_reset_n_o), 8'h2);
    at_edge(105); check("abort_rstn_105", 8'(bus.phy_reset_n_o), 8'h0);
                  check("abort_busy_105", 8'(bus.phy_busy_o),    8'h3);
    at_edge(113); check("abort_rstn_113", 8'(bus.phy_reset_n_o), 8'h3);
    at_edge(114); bus.phy_rst_req_i = 2'b10;
    at_edge(115); bus.phy_rst_req_i = 2'b00;
    at_edge(116); bus.phy_rst_req_i = 2'b01;
    at_edge(117); bus.phy_rst_req_i = 2'b00;
                  check("enter_soc_117", 8'(bus.soc_reset_o), 8'h0);
    at_edge(118); check("ign_busy_118",  8'(bus.phy_busy_o),  8'h0);

    at_edge(127); bus.rst_src_i = 2'b01;
    at_edge(128); bus.rst_src_i = 2'b00;
    at_edge(129); bus.phy_rst_req_i = 2'b10;
                  check("sim_soc_129", 8'(bus.soc_reset_o), 8'h0);
    at_edge(130); bus.phy_rst_req_i = 2'b00;
                  check("sim_soc_130", 8'(bus.soc_reset_o), 8'h1);
    at_edge(142); check("sim_soc_142",  8'(bus.soc_reset_o), 8'h0);
                  check("sim_busy_142", 8'(bus.phy_busy_o),  8'h0);

    at_edge(149); bus.phy_rst_req_i = 2'b10;
    at_edge(150); bus.phy_rst_req_i = 2'b00;
    at_edge(151); check("phy1_rstn_151", 8'(bus.phy_reset_n_o), 8'h1);
                  check("phy1_busy_151", 8'(bus.phy_busy_o),    8'h2);
    at_edge(158); check("phy1_rstn_158", 8'(bus.phy_reset_n_o), 8'h1);
    at_edge(159); check("phy1_rstn_159", 8'(bus.phy_reset_n_o), 8'h3);

    at_edge(169); bus.link_i = 2'b01; bus.rst_src_i = 2'b01;
    at_edge(170); bus.rst_src_i = 2'b00;
`ifdef ETH_PHY_RST_LINK_WAIT_EN
    at_edge(187); check("lnkwait_soc_187", 8'(bus.soc_reset_o), 8'h1);
    at_edge(188); check("lnkwait_soc_188", 8'(bus.soc_reset_o), 8'h0);
`else
    at_edge(183); check("lnkign_soc_183", 8'(bus.soc_reset_o), 8'h1);
    at_edge(184); check("lnkign_soc_184", 8'(bus.soc_reset_o), 8'h0);
`endif
    at_edge(199); bus.link_i = 2'b11; bus.rst_src_i = 2'b01;
    at_edge(200); bus.rst_src_i = 2'b00;
    at_edge(213); check("lnkok_soc_213", 8'(bus.soc_reset_o), 8'h1);
    at_edge(214); check("lnkok_soc_214", 8'(bus.soc_reset_o), 8'h0);

    at_edge(230);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_phy_reset_seq.md
# eth_phy_reset_seq

Board-level reset and PHY power-up sequencer for multi-port Ethernet SoC tops. It merges N asynchronous reset sources, such as a push-button or an in-system JTAG source, into one synchronised sequence. The sequence holds every PHY in hardware reset for a programmed time, then holds the SoC for a settling time before releasing it. In RUN, software can re-reset individual PHYs without disturbing the SoC.

## Interface
Parameters:
- NUM_SRC, 2: number of reset request sources.
- NUM_PHY, 1: number of PHY channels.
- PHY_RST_CYC, 500000: PHY reset assertion length in clk cycles (10 ms at 50 MHz); must be ≥2.
- PHY_WAIT_CYC, 250000: post-PHY-reset settle time before SoC release; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rst_src_i  in  NUM_SRC  active-high reset requests; asynchronous, level.
- phy_rst_req_i  in  NUM_PHY  single-cycle per-PHY reset request, clk domain.
- link_i  in  NUM_PHY  PHY link-up indications; asynchronous.
- soc_reset_o  out  1  active-high SoC reset.
- phy_reset_n_o  out  NUM_PHY  active-low PHY hardware reset.
- phy_busy_o  out  NUM_PHY  high while that PHY is held in reset.
- seq_active_o  out  1  high in any state except RUN (reset LED).

## Operation
- reset_n feeds a 2-FF reset synchroniser: assertion is asynchronous, release is synchronous.
- Each bit of rst_src_i and link_i passes through a 2-FF synchroniser. src_any is the OR of the synchronised rst_src_i bits.
- FSM states: PHY_RST, PHY_WAIT, RUN. The reset state is PHY_RST with the counter at 0.
- **PHY_RST**
  - All phy_reset_n_o are 0; soc_reset_o is 1.
  - The counter increments each cycle while src_any is 0 and is held at 0 while src_any is 1.
  - When the counter reaches PHY_RST_CYC-1, the FSM moves to PHY_WAIT and clears the counter.
- **PHY_WAIT**
  - phy_reset_n_o is all 1; soc_reset_o is 1.
  - The FSM moves to RUN when the counter reaches PHY_WAIT_CYC-1 (see Configuration).
- **RUN**
  - soc_reset_o is 0.
  - A phy_rst_req_i[i] pulse loads channel counter i. phy_reset_n_o[i] is driven 0 and phy_busy_o[i] is driven 1 for exactly PHY_RST_CYC cycles.
  - A repeated request during that pulse reloads the counter, extending the pulse.
- src_any=1 in any state forces PHY_RST with the counter at 0 and aborts all channel pulses.
- phy_rst_req_i is ignored outside RUN.
- Counters use width $clog2(max(PHY_RST_CYC, 2*PHY_WAIT_CYC)+1) and never wrap; each saturates at its terminal value.

## Timing
- All outputs are registered.
- Reset values: soc_reset_o=1, phy_reset_n_o=0, phy_busy_o=all 1, seq_active_o=1.
- From reset_n release:
  - The internal reset deasserts at the 2nd clk edge.
  - phy_reset_n_o rises PHY_RST_CYC cycles later.
  - soc_reset_o falls PHY_WAIT_CYC cycles after that.
- rst_src_i rise to soc_reset_o=1 and phy_reset_n_o=0: 3 clk edges (2 sync + 1 register).
- Source release: PHY_RST counting starts 2 edges after rst_src_i falls.
- phy_rst_req_i[i] sampled at edge k: phy_reset_n_o[i]=0 from edge k+1 through edge k+PHY_RST_CYC.
- Simultaneous src_any and phy_rst_req_i: src_any wins.
- Per-channel request on the same cycle as the FSM entering RUN: ignored.

## Configuration
- Macro: ETH_PHY_RST_LINK_WAIT_EN.
- Defined: PHY_WAIT exits only when the counter is ≥ PHY_WAIT_CYC-1 and either the synchronised link_i is all 1, or the counter reaches 2*PHY_WAIT_CYC-1 (timeout). Exit on timeout still enters RUN.
- Undefined: link_i is ignored and PHY_WAIT lasts exactly PHY_WAIT_CYC cycles.

## Test plan
Common parameters: NUM_SRC=2, NUM_PHY=2, PHY_RST_CYC=8, PHY_WAIT_CYC=4.
- **Power-up:** release reset_n at edge 0 -> phy_reset_n_o=2'b11 at edge 10, soc_reset_o=0 at edge 14, seq_active_o=0 at edge 14.
- **Source during RUN:** in RUN, rst_src_i[1]=1 for 20 cycles -> soc_reset_o=1 and phy_reset_n_o=0 three edges after the rise. The full sequence then restarts; phy_reset_n_o rises 10 edges after the fall.
- **Per-PHY reset:** in RUN, pulse phy_rst_req_i=2'b01 -> phy_reset_n_o=2'b10 and phy_busy_o=2'b01 for exactly 8 cycles; soc_reset_o stays 0.
- **Re-request:** pulse phy_rst_req_i[0] again after 5 cycles -> total low time 13 cycles.
- **Abort:** rst_src_i[0] rises mid-pulse -> both PHYs held low, channel pulse cleared, and the FSM re-sequences.
- **Link wait (macro defined):** link_i=2'b01 -> RUN entered at PHY_WAIT count 7 (timeout).
- **Link ready (macro defined):** link_i=2'b11 -> RUN entered at count 3, matching the undefined case.
